// File: rtl/serial_debug_node.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// serial_debug_node: store-forward debug ring node (144-bit frames, R/W reg)
// Revision: 1.0
// ============================================================================
module serial_debug_node #(
  parameter logic [14:0] NODE_ADDR = 15'h0001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   prescaler,
  input  logic         debug_in_data,
  input  logic         debug_in_clk,
  output logic         debug_out_data,
  output logic         debug_out_clk,
  output logic [127:0] dbg_out,
  output logic         dbg_write_stb,
  input  logic [127:0] dbg_in,
  output logic         dbg_read_stb
);

  localparam logic [7:0]  FRAME_BITS = 8'd144;
  localparam logic [14:0] BCAST_ADDR = 15'h7FFF;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_PROC = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   clk_sync;
  logic         clk_hist;
  logic [1:0]   data_sync;
  logic [143:0] buffer;
  logic [7:0]   bit_cnt;
  logic [7:0]   prescale_cnt;
  logic [7:0]   bits_left;
  logic         in_rise;
  logic         in_bit;
  logic         tick;
  logic         frame_dir;
  logic         addr_match;
  logic         addr_bcast;

  // Clock stages reset high so a released reset never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      clk_hist  <= 1'b1;
      data_sync <= 2'b00;
    end else begin
      clk_sync  <= {clk_sync[0], debug_in_clk};
      clk_hist  <= clk_sync[1];
      data_sync <= {data_sync[0], debug_in_data};
    end
  end

  assign in_rise    = ~clk_hist & clk_sync[1];
  assign in_bit     = data_sync[1];
  assign tick       = (prescale_cnt <= 8'd1);
  assign frame_dir  = buffer[143];
  assign addr_match = (buffer[142:128] == NODE_ADDR);
  assign addr_bcast = (buffer[142:128] == BCAST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RX;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RX:   if (in_rise && (bit_cnt == FRAME_BITS - 8'd1)) state_next = ST_PROC;
      ST_PROC: state_next = ST_TX;
      ST_TX:   if (tick && debug_out_clk && (bits_left == 8'd0)) state_next = ST_RX;
      default: state_next = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer         <= '0;
      bit_cnt        <= 8'd0;
      prescale_cnt   <= 8'd0;
      bits_left      <= 8'd0;
      debug_out_clk  <= 1'b1;
      debug_out_data <= 1'b0;
      dbg_out        <= '0;
      dbg_write_stb  <= 1'b0;
      dbg_read_stb   <= 1'b0;
    end else begin
      dbg_write_stb <= 1'b0;
      dbg_read_stb  <= 1'b0;
      case (state)
        ST_RX: begin
          if (in_rise) begin
            buffer  <= {buffer[142:0], in_bit};
            bit_cnt <= (bit_cnt == FRAME_BITS - 8'd1) ? 8'd0 : bit_cnt + 8'd1;
          end
        end
        ST_PROC: begin
          if (frame_dir && (addr_match || addr_bcast)) begin
            dbg_out       <= buffer[127:0];
            dbg_write_stb <= 1'b1;
          end
          if (!frame_dir && addr_match) begin
            buffer[127:0] <= dbg_in;
            dbg_read_stb  <= 1'b1;
          end
          prescale_cnt  <= prescaler;
          bits_left     <= FRAME_BITS;
          debug_out_clk <= 1'b1;
        end
        ST_TX: begin
          if (tick) begin
            prescale_cnt <= prescaler;
            // Data changes only while the clock is high, a full half-period before it rises.
            if (debug_out_clk) begin
              debug_out_data <= buffer[143];
              buffer         <= {buffer[142:0], 1'b0};
              if (bits_left != 8'd0) begin
                bits_left     <= bits_left - 8'd1;
                debug_out_clk <= 1'b0;
              end
            end else begin
              debug_out_clk <= 1'b1;
            end
          end else begin
            prescale_cnt <= prescale_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_debug_node.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_serial_debug_node: scoreboard bench for the debug ring node
// Revision: 1.0
// ============================================================================
module tb_serial_debug_node;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   prescaler = 8'd2;
  logic         debug_in_data = 1'b0;
  logic         debug_in_clk = 1'b1;
  logic         debug_out_data;
  logic         debug_out_clk;
  logic [127:0] dbg_out;
  logic         dbg_write_stb;
  logic [127:0] dbg_in = '0;
  logic         dbg_read_stb;

  serial_debug_node #(.NODE_ADDR(15'h0001)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .prescaler      (prescaler),
    .debug_in_data  (debug_in_data),
    .debug_in_clk   (debug_in_clk),
    .debug_out_data (debug_out_data),
    .debug_out_clk  (debug_out_clk),
    .dbg_out        (dbg_out),
    .dbg_write_stb  (dbg_write_stb),
    .dbg_in         (dbg_in),
    .dbg_read_stb   (dbg_read_stb)
  );

  always #5 clk = ~clk;

  int           vectors = 0;
  int           miscompares = 0;
  logic [143:0] exp_frame_q[$];
  logic [127:0] exp_wr_q[$];
  int           out_edges = 0;
  int           out_bits = 0;
  logic [143:0] out_sr = '0;
  int           cyc = 0;
  int           last_edge_cyc = 0;
  bit           armed = 1'b0;
  int           rd_pulses = 0;
  logic         prev_wr = 1'b0;
  logic         prev_rd = 1'b0;
  logic         prev_oc = 1'b1;
  logic [127:0] model_out = '0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pval();
    return (prescaler == 8'd0) ? 1 : int'(prescaler);
  endfunction

  // Monitor: reassembles the forwarded frame and polices strobes.
  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      if (!prev_oc && debug_out_clk) begin
        if (out_bits > 0) check("out_period", cyc - last_edge_cyc, 2 * pval());
        last_edge_cyc = cyc;
        out_edges++;
        out_sr = {out_sr[142:0], debug_out_data};
        out_bits++;
        if (out_bits == 144) begin
          out_bits = 0;
          if (exp_frame_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_unexpected: got %0h expected none", out_sr);
          end else begin
            check("frame_data", out_sr, exp_frame_q.pop_front());
          end
        end
      end
      if (dbg_write_stb) begin
        check("wr_stb_width", prev_wr, 1'b0);
        if (exp_wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL wr_stb_unexpected: got dbg_out %0h expected no strobe", dbg_out);
        end else begin
          check("dbg_out_on_stb", dbg_out, exp_wr_q.pop_front());
        end
      end
      if (dbg_read_stb) begin
        check("rd_stb_width", prev_rd, 1'b0);
        rd_pulses++;
      end
    end
    prev_oc = debug_out_clk;
    prev_wr = dbg_write_stb;
    prev_rd = dbg_read_stb;
  end

  task automatic send_bits(input logic [143:0] f, input int n);
    for (int i = 143; i > 143 - n; i--) begin
      debug_in_clk  = 1'b0;
      debug_in_data = f[i];
      #30;
      debug_in_clk  = 1'b1;
      #30;
    end
  endtask

  task automatic run_frame(input logic [143:0] f, input logic [143:0] fwd,
                           input bit wr_exp, input bit rd_exp, input bit inject);
    int target = out_edges + 144;
    int rd0 = rd_pulses;
    int budget;
    exp_frame_q.push_back(fwd);
    if (wr_exp) begin
      exp_wr_q.push_back(f[127:0]);
      model_out = f[127:0];
    end
    send_bits(f, 144);
    if (inject) begin
      repeat (20) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        debug_in_clk  = 1'b0;
        debug_in_data = k[0];
        #30;
        debug_in_clk  = 1'b1;
        #30;
      end
    end
    budget = 300 * pval() + 100;
    while (out_edges < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (2 * pval() + 10) @(negedge clk);
    check("edge_count", out_edges, target);
    check("frame_pending", exp_frame_q.size(), 0);
    check("wr_stb_pending", exp_wr_q.size(), 0);
    check("rd_stb_count", rd_pulses - rd0, rd_exp);
    check("dbg_out_hold", dbg_out, model_out);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [143:0] f;
    int edges0;
    repeat (5) @(negedge clk);
    check("rst_out_clk", debug_out_clk, 1'b1);
    check("rst_out_data", debug_out_data, 1'b0);
    check("rst_dbg_out", dbg_out, 128'h0);
    check("rst_wr_stb", dbg_write_stb, 1'b0);
    check("rst_rd_stb", dbg_read_stb, 1'b0);
    rst_n = 1'b1;
    armed = 1'b1;
    repeat (5) @(negedge clk);

    // Non-matching write: forwarded untouched, no strobe, dbg_out stays 0.
    f = {1'b1, 15'h0002, {128{1'b1}}};
    run_frame(f, f, 1'b0, 1'b0, 1'b0);

    f = {1'b1, 15'h0001, 128'hDEADBEEF_0011_2233_4455_6677_8899_AABB};
    run_frame(f, f, 1'b1, 1'b0, 1'b0);

    dbg_in = 128'h0123456789ABCDEF_FEDCBA9876543210;
    run_frame({1'b0, 15'h0001, 128'h0},
              {1'b0, 15'h0001, 128'h0123456789ABCDEF_FEDCBA9876543210},
              1'b0, 1'b1, 1'b0);

    f = {1'b1, 15'h7FFF, {16{8'h5A}}};
    run_frame(f, f, 1'b1, 1'b0, 1'b0);

    f = {1'b0, 15'h7FFF, 128'hCAFEF00D_1357_9BDF_0246_8ACE_1111_2222};
    run_frame(f, f, 1'b0, 1'b0, 1'b0);

    // Reset after 70 bits of a write frame; only the following frame counts.
    edges0 = out_edges;
    send_bits({1'b1, 15'h0001, 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0}, 70);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_out_clk", debug_out_clk, 1'b1);
    check("mid_rst_out_data", debug_out_data, 1'b0);
    check("mid_rst_dbg_out", dbg_out, 128'h0);
    check("mid_rst_wr_stb", dbg_write_stb, 1'b0);
    check("mid_rst_rd_stb", dbg_read_stb, 1'b0);
    model_out = '0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_edges", out_edges, edges0);
    f = {1'b1, 15'h0001, 128'h11223344_55667788_99AABBCC_DDEEFF00};
    run_frame(f, f, 1'b1, 1'b0, 1'b0);

    // prescaler 0 behaves like 1 (period 2 cycles).
    prescaler = 8'd0;
    f = {1'b0, 15'h0003, 128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A};
    run_frame(f, f, 1'b0, 1'b0, 1'b0);

    // Upstream edges injected during TX must be ignored.
    prescaler = 8'd1;
    f = {1'b1, 15'h0001, 128'h00000000_00000000_00000000_000000FF};
    run_frame(f, f, 1'b1, 1'b0, 1'b1);
    prescaler = 8'd3;
    dbg_in = 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555;
    run_frame({1'b0, 15'h0001, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000},
              {1'b0, 15'h0001, 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555},
              1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
